board_scan_ctrl: RTL

Parametrised successor to the fixed 7x5 board logic: a ROWS x COLS battleship board controller that latches a ship map, takes debounced fire requests at a switch-selected coordinate, tracks shot and hit marks, counts shots and hits, and flags game over. It also time-multiplexes the selected board view onto a column-scanned LED matrix. It sits between the switch/button inputs and the matrix and 7-segment drivers at top level.

---
 rtl/board_pkg.sv | 20 ++
 rtl/board_col_scan.sv | 48 ++++
 rtl/board_scan_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared mode/result codes and FSM state type for the board controller
package board_pkg;

    localparam logic [1:0] MODE_BLANK  = 2'b00;
    localparam logic [1:0] MODE_SHIP   = 2'b01;
    localparam logic [1:0] MODE_ATTACK = 2'b10;
    localparam logic [1:0] MODE_HITS   = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_MISS = 2'b01;
    localparam logic [1:0] RES_HIT  = 2'b10;
    localparam logic [1:0] RES_REJ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_OVER  = 2'b10
    } state_e;

endpackage

// File: rtl/board_col_scan.sv
// rtl/board_col_scan.sv - column prescaler, column index and one-hot column drive
module board_col_scan #(
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 50000,
    localparam int CW      = $clog2(COLS),
    localparam int PW      = $clog2(SCAN_DIV)
) (
    input  logic            clk,
    input  logic            clr_n,
    output logic [CW-1:0]   col_idx_o,
    output logic [CW-1:0]   col_next_o,
    output logic [COLS-1:0] m_col_o
);

    logic [PW-1:0]   pre_q, pre_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] m_col_q, m_col_d;
    logic            tc;

    // Prescaler terminal count advances the column; the one-hot drive follows the next index
    always_comb begin
        tc      = (pre_q == PW'(SCAN_DIV - 1));
        pre_d   = tc ? '0 : pre_q + PW'(1);
        col_d   = col_q;
        if (tc) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        end
        m_col_d = COLS'(1) << col_d;
    end

    // Scan state registers; reset restarts at column 0
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_q   <= '0;
            col_q   <= '0;
            m_col_q <= COLS'(1);
        end else begin
            pre_q   <= pre_d;
            col_q   <= col_d;
            m_col_q <= m_col_d;
        end
    end

    assign col_idx_o  = col_q;
    assign col_next_o = col_d;
    assign m_col_o    = m_col_q;

endmodule

// File: rtl/board_scan_ctrl.sv
// rtl/board_scan_ctrl.sv - battleship board controller with column-scanned LED matrix output
module board_scan_ctrl
    import board_pkg::*;
#(
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 50000,
    localparam int RW      = $clog2(ROWS),
    localparam int CW      = $clog2(COLS),
    localparam int SW      = $clog2(ROWS*COLS+1)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 new_game,
    input  logic [1:0]           mode,
    input  logic [ROWS*COLS-1:0] ship_map,
    input  logic [RW-1:0]        row_sel,
    input  logic [CW-1:0]        col_sel,
    input  logic                 fire,
    output logic [COLS-1:0]      m_col,
    output logic [ROWS-1:0]      m_line,
    output logic [SW-1:0]        shot_cnt,
    output logic [SW-1:0]        hit_cnt,
    output logic [1:0]           last_result,
    output logic                 game_over
);

    localparam int CELLS = ROWS * COLS;
    localparam int IW    = $clog2(CELLS);

    state_e           state_q;
    logic [CELLS-1:0] ship_q, shot_q, hit_q;
    logic [SW-1:0]    shot_cnt_q, hit_cnt_q;
    logic [1:0]       result_q;
    logic             over_q;
    logic             fire_s1_q, fire_s2_q, fire_prev_q;
    logic [ROWS-1:0]  m_line_q, m_line_d;

    logic             fire_pulse;
    logic             in_range;
    logic [IW-1:0]    cell_idx;
    logic             cell_shot, cell_ship;
    logic [SW-1:0]    ship_cnt;
    logic [SW-1:0]    shot_cnt_d, hit_cnt_d;
    logic [CW-1:0]    col_idx, col_next;
    logic [CELLS-1:0] src;
    logic [IW-1:0]    pix_idx;

    board_col_scan #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk        (clk),
        .clr_n      (clr_n),
        .col_idx_o  (col_idx),
        .col_next_o (col_next),
        .m_col_o    (m_col)
    );

    // Two-flop synchroniser plus a delayed copy for rising-edge detection of the button
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            fire_s1_q   <= fire;
            fire_s2_q   <= fire_s1_q;
            fire_prev_q <= fire_s2_q;
        end
    end

    assign fire_pulse = fire_s2_q & ~fire_prev_q;

    // Target decode, latched ship count and saturating counter increments
    always_comb begin
        in_range   = (int'(row_sel) < ROWS) && (int'(col_sel) < COLS);
        cell_idx   = IW'(int'(row_sel) * COLS + int'(col_sel));
        cell_shot  = shot_q[cell_idx];
        cell_ship  = ship_q[cell_idx];
        ship_cnt   = '0;
        for (int i = 0; i < CELLS; i++) begin
            ship_cnt = ship_cnt + SW'(ship_q[i]);
        end
        shot_cnt_d = (shot_cnt_q == SW'(CELLS)) ? shot_cnt_q : shot_cnt_q + SW'(1);
        hit_cnt_d  = (hit_cnt_q  == SW'(CELLS)) ? hit_cnt_q  : hit_cnt_q  + SW'(1);
    end

    // Game FSM with marks, counters and result; new_game wins over a coincident shot
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            ship_q     <= '0;
            shot_q     <= '0;
            hit_q      <= '0;
            shot_cnt_q <= '0;
            hit_cnt_q  <= '0;
            result_q   <= RES_NONE;
            over_q     <= 1'b0;
        end else if (new_game) begin
            state_q    <= ST_IDLE;
            shot_q     <= '0;
            hit_q      <= '0;
            shot_cnt_q <= '0;
            hit_cnt_q  <= '0;
            result_q   <= RES_NONE;
            over_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode == MODE_ATTACK) begin
                        state_q <= ST_ARMED;
                        ship_q  <= ship_map;
                    end
                end
                ST_ARMED: begin
                    if (mode != MODE_ATTACK) begin
                        state_q <= ST_IDLE;
                    end
                    if (fire_pulse) begin
                        if (!in_range || cell_shot) begin
                            result_q <= RES_REJ;
                        end else begin
                            shot_q[cell_idx] <= 1'b1;
                            shot_cnt_q       <= shot_cnt_d;
                            if (cell_ship) begin
                                hit_q[cell_idx] <= 1'b1;
                                hit_cnt_q       <= hit_cnt_d;
                                result_q        <= RES_HIT;
                                if ((hit_cnt_d == ship_cnt) && (ship_cnt != '0)) begin
                                    state_q <= ST_OVER;
                                    over_q  <= 1'b1;
                                end
                            end else begin
                                result_q <= RES_MISS;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    state_q <= ST_OVER;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Row data for the column about to be driven, so column and data change together
    always_comb begin
        unique case (mode)
            MODE_BLANK:  src = '0;
            MODE_SHIP:   src = ship_map;
            MODE_ATTACK: src = shot_q;
            MODE_HITS:   src = hit_q;
            default:     src = '0;
        endcase
        m_line_d = '1;
        pix_idx  = '0;
        for (int r = 0; r < ROWS; r++) begin
            pix_idx     = IW'(r * COLS + int'(col_next));
            m_line_d[r] = ~src[pix_idx];
        end
    end

    // Registered active-low row drive
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_line_q <= '1;
        end else begin
            m_line_q <= m_line_d;
        end
    end

    logic unused_col_idx;
    assign unused_col_idx = ^col_idx;

    assign m_line      = m_line_q;
    assign shot_cnt    = shot_cnt_q;
    assign hit_cnt     = hit_cnt_q;
    assign last_result = result_q;
    assign game_over   = over_q;

endmodule
